// File: rtl/matrix_output_controller.sv
// matrix_output_controller: streams a stored matrix to the UART encoder as element/separator/newline tokens.
// Define OUTPUT_HEADER_EN to prefix each print with header tokens (m, n) and a newline.
module matrix_output_controller #(
    parameter int MAX_DIM = 5,
    parameter int RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  start_id,
    input  logic [3:0]  start_m,
    input  logic [3:0]  start_n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        read_en,
    output logic [6:0]  read_id,
    output logic [3:0]  read_row,
    output logic [3:0]  read_col,
    input  logic [31:0] read_data,
    output logic        tx_valid,
    output logic [1:0]  tx_kind,
    output logic [31:0] tx_data,
    input  logic        tx_ready
);
    typedef enum logic [3:0] {
        IDLE, CHECK, READ, WAIT, SEND, SEP, NL, FIN
`ifdef OUTPUT_HEADER_EN
        , HDR_M, HDR_N, HDR_NL
`endif
    } state_t;

    state_t     state;
    logic [6:0] id_q;
    logic [3:0] m_q, n_q, row, col;
    logic [1:0] lat;
    logic       xfer, bad_dims, last_col, last_row;

    assign xfer     = tx_valid & tx_ready;
    assign bad_dims = (m_q == 4'd0) | (n_q == 4'd0) | (m_q > 4'(MAX_DIM)) | (n_q > 4'(MAX_DIM));
    // Only evaluated after CHECK, so dims are at least 1 and the subtraction cannot wrap.
    assign last_col = col == n_q - 4'd1;
    assign last_row = row == m_q - 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            id_q     <= '0;
            m_q      <= '0;
            n_q      <= '0;
            row      <= '0;
            col      <= '0;
            lat      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            read_en  <= 1'b0;
            read_id  <= '0;
            read_row <= '0;
            read_col <= '0;
            tx_valid <= 1'b0;
            tx_kind  <= '0;
            tx_data  <= '0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            read_en <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    id_q  <= start_id;
                    m_q   <= start_m;
                    n_q   <= start_n;
                    row   <= '0;
                    col   <= '0;
                    busy  <= 1'b1;
                    state <= CHECK;
                end
                CHECK: if (bad_dims) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    err   <= 1'b1;
                    state <= FIN;
                end else begin
                    read_id <= id_q;
`ifdef OUTPUT_HEADER_EN
                    tx_valid <= 1'b1;
                    tx_kind  <= 2'd3;
                    tx_data  <= 32'(m_q);
                    state    <= HDR_M;
`else
                    read_en  <= 1'b1;
                    read_row <= row;
                    read_col <= col;
                    state    <= READ;
`endif
                end
                READ: begin
                    lat   <= 2'd1;
                    state <= WAIT;
                end
                WAIT: if (lat == 2'(RD_LAT)) begin
                    tx_valid <= 1'b1;
                    tx_kind  <= 2'd0;
                    tx_data  <= read_data;
                    state    <= SEND;
                end else begin
                    lat <= lat + 2'd1;
                end
                SEND: if (xfer) begin
                    tx_kind <= last_col ? 2'd2 : 2'd1;
                    tx_data <= '0;
                    state   <= last_col ? NL : SEP;
                end
                SEP: if (xfer) begin
                    tx_valid <= 1'b0;
                    tx_kind  <= 2'd0;
                    col      <= col + 4'd1;
                    read_en  <= 1'b1;
                    read_row <= row;
                    read_col <= col + 4'd1;
                    state    <= READ;
                end
                NL: if (xfer) begin
                    tx_valid <= 1'b0;
                    tx_kind  <= 2'd0;
                    col      <= '0;
                    if (last_row) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        row      <= row + 4'd1;
                        read_en  <= 1'b1;
                        read_row <= row + 4'd1;
                        read_col <= '0;
                        state    <= READ;
                    end
                end
`ifdef OUTPUT_HEADER_EN
                HDR_M: if (xfer) begin
                    tx_data <= 32'(n_q);
                    state   <= HDR_N;
                end
                HDR_N: if (xfer) begin
                    tx_kind <= 2'd2;
                    tx_data <= '0;
                    state   <= HDR_NL;
                end
                HDR_NL: if (xfer) begin
                    tx_valid <= 1'b0;
                    tx_kind  <= 2'd0;
                    read_en  <= 1'b1;
                    read_row <= row;
                    read_col <= col;
                    state    <= READ;
                end
`endif
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_output_controller.sv
// tb_matrix_output_controller: scoreboard bench with a latency-modelled matrix store and a token reference model.
module tb_matrix_output_controller;
    localparam int MAX_DIM = 5;
    localparam int RD_LAT  = 1;

    logic        clk = 0, rst = 1, start = 0, tx_ready = 1;
    logic [6:0]  start_id = '0;
    logic [3:0]  start_m = '0, start_n = '0;
    logic        busy, done, err, read_en, tx_valid;
    logic [6:0]  read_id;
    logic [3:0]  read_row, read_col;
    logic [31:0] read_data, tx_data;
    logic [1:0]  tx_kind;

    int total = 0, bad = 0, rd_cnt = 0, mode = 0, cyc = 0;
    logic [6:0]  cur_id = '0;
    logic [33:0] exp_q[$];
    logic        err_q[$];
    logic [31:0] mem [16][16];
    logic [31:0] pipe [RD_LAT];
    logic        hold_v = 0;
    logic [33:0] hold_tok = '0;

    always #5 clk = ~clk;

    matrix_output_controller #(.MAX_DIM(MAX_DIM), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .start_id(start_id), .start_m(start_m),
        .start_n(start_n), .busy(busy), .done(done), .err(err), .read_en(read_en),
        .read_id(read_id), .read_row(read_row), .read_col(read_col), .read_data(read_data),
        .tx_valid(tx_valid), .tx_kind(tx_kind), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    // Store model: data appears RD_LAT cycles after read_en; a poison value otherwise.
    assign read_data = pipe[RD_LAT-1];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= read_en ? mem[read_row][read_col] : 32'hBAD0_BAD0;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // tx_ready pattern: 0 = always ready, 1 = toggling with a 5-cycle low burst, 2 = random.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        tx_ready = (mode == 0) ? 1'b1 :
                   (mode == 1) ? ((cyc % 2 == 1) && !((cyc % 20) >= 7 && (cyc % 20) < 12)) :
                   1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 0;
        end else begin
            if (hold_v) check("stall_hold", {tx_valid, tx_kind, tx_data}, {1'b1, hold_tok});
            hold_v   = tx_valid && !tx_ready;
            hold_tok = {tx_kind, tx_data};
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_token: got kind=%0d data=%0h required none", tx_kind, tx_data);
                end else begin
                    check("token", {tx_kind, tx_data}, exp_q.pop_front());
                end
            end
            if (read_en) begin
                rd_cnt++;
                check("read_id", read_id, cur_id);
                check("no_read_while_tx", tx_valid, 0);
            end
            if (done) begin
                if (err_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 required none");
                end else begin
                    check("err_flag", err, err_q.pop_front());
                end
            end else if (err) begin
                total++;
                bad++;
                $display("FAIL err_without_done: got err=1 required 0");
            end
        end
    end

    task automatic push_expected(input int m, input int n, input bit ok);
        if (ok) begin
`ifdef OUTPUT_HEADER_EN
            exp_q.push_back({2'd3, 32'(m)});
            exp_q.push_back({2'd3, 32'(n)});
            exp_q.push_back({2'd2, 32'd0});
`endif
            for (int r = 0; r < m; r++)
                for (int c = 0; c < n; c++) begin
                    exp_q.push_back({2'd0, mem[r][c]});
                    exp_q.push_back(c < n - 1 ? {2'd1, 32'd0} : {2'd2, 32'd0});
                end
        end
    endtask

    task automatic print(input logic [6:0] id, input int m, input int n);
        bit ok;
        int t;
        ok = m >= 1 && n >= 1 && m <= MAX_DIM && n <= MAX_DIM;
        t = 0;
        cur_id = id;
        push_expected(m, n, ok);
        err_q.push_back(!ok);
        rd_cnt   = 0;
        start    = 1;
        start_id = id;
        start_m  = 4'(m);
        start_n  = 4'(n);
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        @(negedge clk);
        if (ok) check("first_read_latency", read_en, 1);
        else    check("reject_latency", {done, err}, 2'b11);
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done required done within 3000 cycles");
        end
        check("read_count", rd_cnt, ok ? m * n : 0);
        check("tokens_left", exp_q.size(), 0);
        @(negedge clk);
        check("idle_after_done", {busy, done, tx_valid}, 0);
    endtask

    task automatic fill_random();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) mem[r][c] = $urandom;
    endtask

    initial begin
        int t;
        fill_random();
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, err, read_en, read_id, read_row, read_col,
                                tx_valid, tx_kind, tx_data}, 0);
        rst = 0;
        @(negedge clk);

        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) mem[r][c] = 32'(10 * r + c);
        print(7'd3, 2, 3);

        mem[0][0] = 32'hDEADBEEF;
        print(7'd1, 1, 1);

        print(7'd5, 0, 3);
        print(7'd6, 6, 2);
        print(7'd7, 2, 6);

        fill_random();
        mode = 1;
        print(7'd9, 2, 2);
        print(7'd10, 5, 5);
        mode = 0;

        // Reset mid-print, with an ignored second start while busy.
        fill_random();
        cur_id = 7'd20;
        push_expected(3, 3, 1);
        err_q.push_back(0);
        start = 1; start_id = 7'd20; start_m = 4'd3; start_n = 4'd3;
        @(posedge clk);
        #1 start = 0;
        repeat (4) @(negedge clk);
        start = 1; start_id = 7'd99; start_m = 4'd1; start_n = 4'd1;
        @(negedge clk);
        start = 0;
        t = 0;
        while (exp_q.size() > 12 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("reached_mid_print", exp_q.size() <= 12, 1);
        rst = 1;
        #1;
        check("async_reset_outputs", {busy, done, err, read_en, read_id, read_row, read_col,
                                      tx_valid, tx_kind, tx_data}, 0);
        exp_q.delete();
        err_q.delete();
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        check("no_done_after_reset", {busy, done}, 0);
        print(7'd21, 3, 4);

        mode = 2;
        for (int k = 0; k < 10; k++) begin
            fill_random();
            print(7'($urandom_range(0, 127)), $urandom_range(0, 6), $urandom_range(0, 6));
        end
        mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
